// File: rtl/part5_pkg.sv
// part5_pkg
// Shared constants and helpers for the decode-cloud return path.
//   DEFAULT_FANOUT : default number of request lines
//   rr_next_ptr    : round-robin pointer update after a grant, wrapping at fanout-1
package part5_pkg;

    localparam int DEFAULT_FANOUT = 64;

    // Search should resume just above the last grant. The last line wraps back to 0.
    function automatic int rr_next_ptr(input int grant, input int fanout);
        return (grant == fanout - 1) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/rr_pri_enc.sv
// rr_pri_enc
// Combinational round-robin priority encoder.
// It returns the lowest set request at an index >= ptr. If there is none, it
// falls back to the lowest set request overall.
//   req   : request vector, bit i requests index i
//   ptr   : search start index
//   grant : encoded winning index (0 when no request is set)
//   any   : at least one request bit set
//   multi : more than one request bit set
module rr_pri_enc
    import part5_pkg::*;
#(
    parameter int FANOUT  = DEFAULT_FANOUT,
    parameter int IO_SIZE = $clog2(FANOUT)
) (
    input  logic [FANOUT-1:0]  req,
    input  logic [IO_SIZE-1:0] ptr,
    output logic [IO_SIZE-1:0] grant,
    output logic               any,
    output logic               multi
);

    logic [FANOUT-1:0]  req_masked;
    logic [IO_SIZE-1:0] grant_masked;
    logic [IO_SIZE-1:0] grant_plain;
    logic               any_masked;

    always_comb begin
        req_masked = '0;
        for (int i = 0; i < FANOUT; i++) begin
            req_masked[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Scanning from high to low leaves the lowest set bit as the final winner.
    always_comb begin
        grant_masked = '0;
        grant_plain  = '0;
        for (int i = FANOUT - 1; i >= 0; i--) begin
            if (req_masked[i]) grant_masked = IO_SIZE'(i);
            if (req[i])        grant_plain  = IO_SIZE'(i);
        end
    end

    assign any_masked = |req_masked;
    assign any        = |req;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi      = |(req & (req - FANOUT'(1)));
    assign grant      = any_masked ? grant_masked : grant_plain;

endmodule

// File: rtl/decode_encoder.sv
// decode_encoder
// Compresses a FANOUT-wide request bus into a registered index. It uses
// round-robin priority and presents the result through a valid/ready handshake.
//   clk      : clock, all state on posedge
//   reset    : synchronous active-high reset
//   reqBus   : level-sensitive request lines
//   enable   : gates all requests (0 = no requests)
//   outIdx   : granted index
//   outValid : outIdx holds a grant
//   outReady : consumer accepts outIdx this cycle
//   multiHit : more than one request was set when outIdx was captured
module decode_encoder
    import part5_pkg::*;
#(
    parameter int FANOUT  = DEFAULT_FANOUT,
    parameter int IO_SIZE = $clog2(FANOUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FANOUT-1:0]  reqBus,
    input  logic               enable,
    output logic [IO_SIZE-1:0] outIdx,
    output logic               outValid,
    input  logic               outReady,
    output logic               multiHit
);

    logic [FANOUT-1:0]  req;
    logic [IO_SIZE-1:0] ptr;
    logic [IO_SIZE-1:0] grant;
    logic               any;
    logic               multi;
    logic               load;

    assign req  = reqBus & {FANOUT{enable}};
    // The output register is free when it is empty or is being accepted this
    // cycle. This lets a handshake and the next capture share a clock.
    assign load = !outValid || outReady;

    rr_pri_enc #(
        .FANOUT  (FANOUT),
        .IO_SIZE (IO_SIZE)
    ) u_enc (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .any   (any),
        .multi (multi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid <= 1'b0;
            outIdx   <= '0;
            multiHit <= 1'b0;
            ptr      <= '0;
        end else if (load) begin
            if (any) begin
                outValid <= 1'b1;
                outIdx   <= grant;
                multiHit <= multi;
                ptr      <= IO_SIZE'(rr_next_ptr(int'(grant), FANOUT));
            end else begin
                // An idle load only empties the register. The pointer is not
                // moved, so the fairness order survives gaps in traffic.
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_encoder.sv
module tb_decode_encoder;
    import part5_pkg::*;

    localparam int FANOUT  = 64;
    localparam int IO_SIZE = $clog2(FANOUT);

    typedef struct packed {
        logic [IO_SIZE-1:0] idx;
        logic               multi;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [FANOUT-1:0]  reqBus;
    logic               enable;
    logic [IO_SIZE-1:0] outIdx;
    logic               outValid;
    logic               outReady;
    logic               multiHit;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    decode_encoder #(
        .FANOUT  (FANOUT),
        .IO_SIZE (IO_SIZE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reqBus   (reqBus),
        .enable   (enable),
        .outIdx   (outIdx),
        .outValid (outValid),
        .outReady (outReady),
        .multiHit (multiHit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input bit multi);
        exp_t e;
        e.idx   = IO_SIZE'(idx);
        e.multi = multi;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [FANOUT-1:0] bit_at(input int i);
        logic [FANOUT-1:0] one;
        one = FANOUT'(1);
        return one << i;
    endfunction

    // Monitor: every accepted grant must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && outValid && outReady) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got idx %0d with empty scoreboard", outIdx);
            end else begin
                e = sb_q.pop_front();
                if (outIdx != e.idx || multiHit != e.multi) begin
                    errors++;
                    $display("FAIL grant: got idx %0d multi %0d expected idx %0d multi %0d",
                             outIdx, multiHit, e.idx, e.multi);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        reqBus   = '0;
        enable   = 1'b0;
        outReady = 1'b0;
        #1;
        do_reset();
        chk("reset_valid", int'(outValid), 0);
        chk("reset_idx",   int'(outIdx),   0);
        chk("reset_multi", int'(multiHit), 0);

        // Single request; the follow-up shows ptr moved to 6.
        enable   = 1'b1;
        outReady = 1'b1;
        reqBus   = bit_at(5);
        push(5, 0);
        tick();
        reqBus = bit_at(2) | bit_at(6);
        push(6, 1);
        tick();
        reqBus = '0;
        tick();
        chk("single_idle_valid", int'(outValid), 0);

        // Round robin between 3 and 40.
        do_reset();
        reqBus = bit_at(3) | bit_at(40);
        push(3, 1); push(40, 1); push(3, 1); push(40, 1);
        repeat (4) tick();
        reqBus = '0;
        tick();

        // Backpressure: 7 must hold while the request changes to 9.
        do_reset();
        outReady = 1'b0;
        reqBus   = bit_at(7);
        push(7, 0);
        tick();
        reqBus = bit_at(9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", int'(outValid), 1);
            chk("stall_idx",   int'(outIdx),   7);
        end
        outReady = 1'b1;
        push(9, 0);
        tick();
        reqBus = '0;
        tick();

        // Enable gating. Make ptr=21 first, then gate an all-ones bus.
        do_reset();
        reqBus = bit_at(20);
        push(20, 0);
        tick();
        reqBus = '0;
        tick();
        chk("idle_valid",    int'(outValid), 0);
        chk("idle_idx_hold", int'(outIdx),   20);
        reqBus = '1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gated_valid", int'(outValid), 0);
        end
        enable = 1'b1;
        push(21, 1);
        tick();
        reqBus = '0;
        tick();

        // Wrap: ptr=63, then bits 63 and 0 give 63 then 0.
        do_reset();
        reqBus = bit_at(62);
        push(62, 0);
        tick();
        reqBus = bit_at(63) | bit_at(0);
        push(63, 1); push(0, 1);
        tick();
        tick();
        reqBus = '0;
        tick();

        // Reset while a grant is held.
        do_reset();
        outReady = 1'b0;
        reqBus   = bit_at(12);
        tick();
        chk("hold_valid", int'(outValid), 1);
        chk("hold_idx",   int'(outIdx),   12);
        reqBus = bit_at(3) | bit_at(13);
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_hold_valid", int'(outValid), 0);
        chk("rst_hold_idx",   int'(outIdx),   0);
        chk("rst_hold_multi", int'(multiHit), 0);
        outReady = 1'b1;
        push(3, 1);
        tick();
        reqBus = '0;
        tick();
        tick();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
